// File: rtl/uart_msg_checker_if.sv
// Serial line plus receive/check status bundle for uart_msg_checker.
// master drives the line (stimulus side); slave is the checker.
interface uart_msg_checker_if;
  logic       uart_rxd;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       done;
  logic       pass;
  logic       fail;
  logic [4:0] err_index;

  modport master (
    output uart_rxd,
    input  rx_valid, rx_data, frame_err, done, pass, fail, err_index
  );

  modport slave (
    input  uart_rxd,
    output rx_valid, rx_data, frame_err, done, pass, fail, err_index
  );
endinterface

// File: rtl/uart_msg_checker.sv
// 8N1 UART receiver that checks incoming bytes, in order, against a fixed message
// and latches sticky pass/fail flags plus the index of the first bad byte.
module uart_msg_checker #(
  parameter int unsigned          CLK_HZ   = 100000000,
  parameter int unsigned          BAUD     = 115200,
  parameter int unsigned          MSG_LEN  = 24,
  parameter logic [8*MSG_LEN-1:0] EXPECTED = 192'h21_78_69_6e_69_66_45_20_6d_6f_72_66_20_64_6c_72_6f_57_20_6f_6c_6c_65_48
) (
  input logic                io_systemClk,
  input logic                io_asyncResetn,
  uart_msg_checker_if.slave  bus
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam int unsigned IW   = 5;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state, state_nx;
  logic          rxd_meta, rxd_s, rxd_d;
  logic [1:0]    warm;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_valid_q, frame_err_q;
  logic [7:0]    rx_data_q;
  logic          done_q, pass_q, fail_q;
  logic [IW-1:0] idx, err_index_q;

  logic          fall_c, cnt_done_c, cnt_clr_c, sample_c, stop_ok_c, stop_bad_c;
  logic [7:0]    exp_byte_c;

  // Two-flop synchroniser; armed only once the real line has been seen high after reset
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b1;
      warm     <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rxd_meta <= bus.uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_d    <= rxd_s;
      warm     <= {warm[0], 1'b1};
      armed    <= armed | (warm[1] & rxd_s);
    end
  end

  assign fall_c = armed & rxd_d & ~rxd_s;

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) state <= S_IDLE;
    else                 state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (fall_c)     state_nx = S_START;
      S_START: if (cnt_done_c) state_nx = rxd_s ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_done_c && (bit_idx == 3'd7)) state_nx = S_STOP;
      S_STOP:  if (cnt_done_c) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sample-point decode: half a bit into the start bit, then one full bit apart
  always_comb begin
    cnt_done_c = 1'b0;
    cnt_clr_c  = 1'b0;
    unique case (state)
      S_IDLE:  cnt_clr_c  = 1'b1;
      S_START: cnt_done_c = (cnt == CW'(HALF - 1));
      default: cnt_done_c = (cnt == CW'(DIV - 1));
    endcase
    if (cnt_done_c) cnt_clr_c = 1'b1;
    sample_c   = cnt_done_c && (state == S_DATA);
    stop_ok_c  = cnt_done_c && (state == S_STOP) &&  rxd_s;
    stop_bad_c = cnt_done_c && (state == S_STOP) && !rxd_s;
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      cnt <= cnt_clr_c ? '0 : cnt + CW'(1);
      if ((state == S_START) && cnt_done_c) bit_idx <= '0;
      if (sample_c) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      rx_valid_q  <= stop_ok_c;
      frame_err_q <= stop_bad_c;
      if (stop_ok_c) rx_data_q <= shreg;
    end
  end

  assign exp_byte_c = EXPECTED[{idx, 3'b000} +: 8];

  // Message checker; everything freezes once a verdict is reached
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      idx         <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_index_q <= '0;
    end else if (!done_q) begin
      if (rx_valid_q) begin
        if (rx_data_q != exp_byte_c) begin
          fail_q      <= 1'b1;
          done_q      <= 1'b1;
          err_index_q <= idx;
        end else if (idx == IW'(MSG_LEN - 1)) begin
          pass_q <= 1'b1;
          done_q <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end else if (frame_err_q) begin
        fail_q      <= 1'b1;
        done_q      <= 1'b1;
        err_index_q <= idx;
      end
    end
  end

  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.frame_err = frame_err_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.err_index = err_index_q;

endmodule

// File: tb/tb_uart_msg_checker.sv
// Bench for uart_msg_checker: serial frames driven in real time, results checked
// against a frame-level model of the message check.
`timescale 1ns/1ps
module tb_uart_msg_checker;

  localparam int unsigned CLK_HZ  = 100_000_000;
  localparam int unsigned BAUD    = 3_125_000;
  localparam int unsigned MSG_LEN = 24;
  localparam int unsigned DIV     = CLK_HZ / BAUD;
  localparam int unsigned HALF    = DIV / 2;
  localparam logic [8*MSG_LEN-1:0] EXPECTED =
    192'h21_78_69_6e_69_66_45_20_6d_6f_72_66_20_64_6c_72_6f_57_20_6f_6c_6c_65_48;
  localparam realtime T_CLK = 10.0;
  localparam realtime T_BIT = T_CLK * DIV;

  typedef struct {
    logic [7:0] b;
    bit         stop_ok;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_msg_checker_if bus ();

  uart_msg_checker #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .MSG_LEN (MSG_LEN),
    .EXPECTED(EXPECTED)
  ) dut (
    .io_systemClk  (clk),
    .io_asyncResetn(rst_n),
    .bus           (bus)
  );

  string      golden = "Hello World from Efinix!";
  frame_t     fq[$];
  logic [7:0] rxq[$];
  int         vcyc[$];
  int         ecyc[$];
  int         cyc      = 0;
  int         done_cyc = -1;
  logic       done_prev = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (bus.rx_valid === 1'b1) begin
      rxq.push_back(bus.rx_data);
      vcyc.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) ecyc.push_back(cyc);
    if (bus.done === 1'b1 && done_prev !== 1'b1 && done_cyc < 0) done_cyc = cyc;
    done_prev = bus.done;
  end

  task automatic clear_mon();
    rxq.delete();
    vcyc.delete();
    ecyc.delete();
    done_cyc = -1;
  endtask

  task automatic reset_dut();
    bus.uart_rxd = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input realtime bt);
    bus.uart_rxd = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      #(bt);
    end
    bus.uart_rxd = stop_ok;
    #(bt);
    bus.uart_rxd = 1'b1;
  endtask

  task automatic load_golden();
    fq.delete();
    for (int i = 0; i < MSG_LEN; i++) fq.push_back('{b: golden[i], stop_ok: 1'b1});
  endtask

  task automatic send_all(input int gap_max, input realtime bt);
    foreach (fq[i]) begin
      send_frame(fq[i].b, fq[i].stop_ok, bt);
      if (gap_max > 0) #(T_CLK * $urandom_range(0, gap_max));
    end
    #(bt * 3);
  endtask

  // Frame-level reference: walk the frames, first bad byte or bad stop bit decides
  task automatic check_results(input string name);
    int         idx = 0, err = 0, n_ferr = 0, dec_ord = -1, lat;
    bit         done = 0, pass = 0, fail = 0, dec_ferr = 0;
    logic [7:0] good[$];
    foreach (fq[i]) begin
      if (fq[i].stop_ok) begin
        if (!done) begin
          if (fq[i].b != golden[idx]) begin
            fail = 1; done = 1; err = idx; dec_ferr = 0; dec_ord = good.size();
          end else if (idx == MSG_LEN - 1) begin
            pass = 1; done = 1; dec_ferr = 0; dec_ord = good.size();
          end else begin
            idx++;
          end
        end
        good.push_back(fq[i].b);
      end else begin
        if (!done) begin
          fail = 1; done = 1; err = idx; dec_ferr = 1; dec_ord = n_ferr;
        end
        n_ferr++;
      end
    end
    chk({name, ".n_rx_valid"}, 32'(rxq.size()), 32'(good.size()));
    for (int i = 0; i < good.size() && i < rxq.size(); i++)
      chk($sformatf("%s.rx_data[%0d]", name, i), 32'(rxq[i]), 32'(good[i]));
    chk({name, ".n_frame_err"}, 32'(ecyc.size()), 32'(n_ferr));
    chk({name, ".done"}, 32'(bus.done), 32'(done));
    chk({name, ".pass"}, 32'(bus.pass), 32'(pass));
    chk({name, ".fail"}, 32'(bus.fail), 32'(fail));
    chk({name, ".err_index"}, 32'(bus.err_index), 32'(err));
    if (dec_ord >= 0) begin
      lat = -1;
      if (done_cyc >= 0) begin
        if (dec_ferr && dec_ord < ecyc.size())      lat = done_cyc - ecyc[dec_ord];
        else if (!dec_ferr && dec_ord < vcyc.size()) lat = done_cyc - vcyc[dec_ord];
      end
      chk({name, ".done_latency"}, 32'(lat), 32'd1);
    end
  endtask

  initial begin
    int         k, glen;
    logic [7:0] b;
    bus.uart_rxd = 1'b1;

    // Reset values
    reset_dut();
    chk("reset.rx_valid",  32'(bus.rx_valid),  32'd0);
    chk("reset.rx_data",   32'(bus.rx_data),   32'd0);
    chk("reset.frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset.done",      32'(bus.done),      32'd0);
    chk("reset.pass",      32'(bus.pass),      32'd0);
    chk("reset.fail",      32'(bus.fail),      32'd0);
    chk("reset.err_index", 32'(bus.err_index), 32'd0);

    // Golden message, back-to-back frames
    load_golden();
    send_all(0, T_BIT);
    check_results("golden");

    // Byte 6 'W' replaced by 0x77
    reset_dut();
    load_golden();
    fq[6].b = 8'h77;
    send_all(0, T_BIT);
    check_results("mismatch6");

    // Frame error on the first byte
    reset_dut();
    fq.delete();
    fq.push_back('{b: 8'h48, stop_ok: 1'b0});
    send_all(0, T_BIT);
    check_results("frame_err");

    // Short glitch, then a single good byte
    reset_dut();
    glen = $urandom_range(3, HALF - 4);
    bus.uart_rxd = 1'b0;
    #(T_CLK * glen);
    bus.uart_rxd = 1'b1;
    #(T_BIT * 2);
    chk("glitch.no_rx_valid",  32'(rxq.size()),  32'd0);
    chk("glitch.no_frame_err", 32'(ecyc.size()), 32'd0);
    fq.delete();
    fq.push_back('{b: 8'h48, stop_ok: 1'b1});
    send_all(0, T_BIT);
    check_results("glitch_then_H");

    // Reset during bit 4 of byte 3, line held low across release
    reset_dut();
    for (int i = 0; i < 3; i++) send_frame(golden[i], 1'b1, T_BIT);
    b = golden[3];
    bus.uart_rxd = 1'b0;
    #(T_BIT);
    for (int i = 0; i < 4; i++) begin
      bus.uart_rxd = b[i];
      #(T_BIT);
    end
    bus.uart_rxd = b[4];
    #(T_BIT / 2);
    rst_n = 1'b0;
    bus.uart_rxd = 1'b0;
    #(T_CLK * 3);
    chk("midreset.rx_valid",  32'(bus.rx_valid),  32'd0);
    chk("midreset.rx_data",   32'(bus.rx_data),   32'd0);
    chk("midreset.frame_err", 32'(bus.frame_err), 32'd0);
    chk("midreset.done",      32'(bus.done),      32'd0);
    chk("midreset.pass",      32'(bus.pass),      32'd0);
    chk("midreset.fail",      32'(bus.fail),      32'd0);
    chk("midreset.err_index", 32'(bus.err_index), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    #(T_BIT * 3);
    chk("midreset.low_no_rx",   32'(rxq.size()),  32'd0);
    chk("midreset.low_no_ferr", 32'(ecyc.size()), 32'd0);
    bus.uart_rxd = 1'b1;
    #(T_BIT * 2);
    load_golden();
    send_all(0, T_BIT);
    check_results("after_midreset");

    // +2% baud skew
    reset_dut();
    load_golden();
    send_all(0, T_BIT / 1.02);
    check_results("skew_plus2");

    // Random corruption (bad byte or bad stop bit) with random idle gaps
    for (int r = 0; r < 2; r++) begin
      reset_dut();
      load_golden();
      k = $urandom_range(0, MSG_LEN - 1);
      if ($urandom_range(0, 1) == 0) fq[k].b = fq[k].b ^ 8'(1 << $urandom_range(0, 7));
      else                           fq[k].stop_ok = 1'b0;
      send_all(2 * DIV, T_BIT);
      check_results($sformatf("random%0d_k%0d", r, k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
